// File: rtl/sel_mux_pipe.sv
// -----------------------------------------------------------------------------
// sel_mux_pipe
//   N-way datapath select followed by a chain of pipeline registers. It is used
//   for register-destination, ALU-source and writeback select in the pipelined
//   CPU. The selected word travels through STAGES registered stages along with
//   its valid bit and the select value that produced it. The stages support
//   stall and flush with ordinary pipeline-register semantics.
//
//   Selects at or above N_IN return DEFAULT instead of silently reading zero,
//   and raise a sticky sel_err flag so that decoder bugs are visible.
//
// Parameters
//   WIDTH    data word width
//   N_IN     number of selectable inputs, 2 .. 2**SEL_W
//   SEL_W    select field width
//   STAGES   register stages between the select and the outputs, 1 .. 4
//   DEFAULT  word driven for an out-of-range select
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous, active-low reset
//   in_bus     packed inputs; input k occupies [k*WIDTH +: WIDTH]
//   sel        input index
//   in_valid   current sel/in_bus is a real instruction (not a bubble)
//   stall      hold all stages
//   flush      kill all in-flight entries (wins over stall)
//   err_clr    clear the sticky sel_err
//   out_data   data from the last stage
//   out_valid  last stage holds a valid entry
//   out_sel    select value carried with out_data, for trace/debug
//   sel_err    sticky out-of-range select flag
// -----------------------------------------------------------------------------
module sel_mux_pipe #(
    parameter int                WIDTH   = 32,
    parameter int                N_IN    = 4,
    parameter int                SEL_W   = 3,
    parameter int                STAGES  = 1,
    parameter logic [WIDTH-1:0]  DEFAULT = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_IN*WIDTH-1:0]    in_bus,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     sel_err
);

    // Parameter sanity, caught at elaboration.
    generate
        if (N_IN < 2 || N_IN > (1 << SEL_W)) begin : g_bad_n_in
            $error("sel_mux_pipe: N_IN=%0d must be within 2..2**SEL_W", N_IN);
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("sel_mux_pipe: STAGES=%0d must be within 1..4", STAGES);
        end
    endgenerate

    // N_IN held one bit wider than sel so N_IN == 2**SEL_W is representable
    // and the range compare never truncates sel.
    localparam logic [SEL_W:0] N_IN_W = (SEL_W+1)'(N_IN);

    logic [WIDTH-1:0] mux_d;
    logic             sel_oor;

    assign sel_oor = ({1'b0, sel} >= N_IN_W);

    // Compare-and-pick rather than a variable part-select, so an
    // out-of-range sel never indexes past the end of in_bus.
    always_comb begin
        mux_d = DEFAULT;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_d = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    logic [WIDTH-1:0] stg_data  [STAGES];
    logic             stg_valid [STAGES];
    logic [SEL_W-1:0] stg_sel   [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stg_data[i]  <= DEFAULT;
                stg_valid[i] <= 1'b0;
                stg_sel[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                stg_data[i]  <= DEFAULT;
                stg_valid[i] <= 1'b0;
                stg_sel[i]   <= '0;
            end
        end else if (!stall) begin
            // Bubbles still carry their data; only the valid bit is dropped.
            stg_data[0]  <= mux_d;
            stg_valid[0] <= in_valid;
            stg_sel[0]   <= sel;
            for (int i = 1; i < STAGES; i++) begin
                stg_data[i]  <= stg_data[i-1];
                stg_valid[i] <= stg_valid[i-1];
                stg_sel[i]   <= stg_sel[i-1];
            end
        end
    end

    // Only an advancing, valid instruction can record an error; a new error
    // beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (!flush && !stall && in_valid && sel_oor) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    assign out_data  = stg_data[STAGES-1];
    assign out_valid = stg_valid[STAGES-1];
    assign out_sel   = stg_sel[STAGES-1];

endmodule

// File: tb/tb_sel_mux_pipe.sv
module tb_sel_mux_pipe;

    localparam int WIDTH  = 32;
    localparam int N_IN   = 4;
    localparam int SEL_W  = 3;
    localparam int STAGES = 2;
    localparam int NVEC   = 24;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [N_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic                  err_clr;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [SEL_W-1:0]      out_sel;
    logic                  sel_err;

    sel_mux_pipe #(
        .WIDTH   (WIDTH),
        .N_IN    (N_IN),
        .SEL_W   (SEL_W),
        .STAGES  (STAGES),
        .DEFAULT ('0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_bus    (in_bus),
        .sel       (sel),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .err_clr   (err_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  sel;
        logic        vld;
        logic        stall;
        logic        flush;
        logic        clr;
        logic [31:0] e_data;
        logic        e_valid;
        logic [2:0]  e_sel;
        logic        e_err;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [2:0] s, input logic v, input logic st,
                                input logic fl, input logic cl, input logic [31:0] ed,
                                input logic ev, input logic [2:0] es, input logic ee);
        vec_t r;
        r.sel = s; r.vld = v; r.stall = st; r.flush = fl; r.clr = cl;
        r.e_data = ed; r.e_valid = ev; r.e_sel = es; r.e_err = ee;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ed, input logic ev,
                           input logic [2:0] es, input logic ee);
        chk({tag, " out_data"},  out_data,         ed);
        chk({tag, " out_valid"}, 32'(out_valid),   32'(ev));
        chk({tag, " out_sel"},   32'(out_sel),     32'(es));
        chk({tag, " sel_err"},   32'(sel_err),     32'(ee));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic v, input logic st,
                         input logic fl, input logic cl);
        sel = s; in_valid = v; stall = st; flush = fl; err_clr = cl;
    endtask

    initial begin
        //             sel  v  st fl cl  exp_data       ev es  ee
        vecs[0]  = mk(3'd0, 1, 0, 0, 0, 32'h0000_0000, 0, 3'd0, 0);
        vecs[1]  = mk(3'd1, 1, 0, 0, 0, 32'hAAAA_0000, 1, 3'd0, 0);
        vecs[2]  = mk(3'd2, 1, 0, 0, 0, 32'hBBBB_0001, 1, 3'd1, 0);
        vecs[3]  = mk(3'd3, 1, 0, 0, 0, 32'hCCCC_0002, 1, 3'd2, 0);
        vecs[4]  = mk(3'd5, 1, 0, 0, 0, 32'hDDDD_0003, 1, 3'd3, 1);
        vecs[5]  = mk(3'd0, 0, 0, 0, 0, 32'h0000_0000, 1, 3'd5, 1);
        vecs[6]  = mk(3'd0, 0, 0, 0, 1, 32'hAAAA_0000, 0, 3'd0, 0);
        vecs[7]  = mk(3'd6, 1, 0, 0, 1, 32'hAAAA_0000, 0, 3'd0, 1);
        vecs[8]  = mk(3'd0, 0, 0, 0, 1, 32'h0000_0000, 1, 3'd6, 0);
        vecs[9]  = mk(3'd7, 0, 0, 0, 0, 32'hAAAA_0000, 0, 3'd0, 0);
        vecs[10] = mk(3'd7, 0, 0, 0, 0, 32'h0000_0000, 0, 3'd7, 0);
        vecs[11] = mk(3'd3, 1, 0, 0, 0, 32'h0000_0000, 0, 3'd7, 0);
        vecs[12] = mk(3'd1, 1, 0, 0, 0, 32'hDDDD_0003, 1, 3'd3, 0);
        vecs[13] = mk(3'd2, 1, 1, 0, 0, 32'hDDDD_0003, 1, 3'd3, 0);
        vecs[14] = mk(3'd2, 1, 1, 0, 0, 32'hDDDD_0003, 1, 3'd3, 0);
        vecs[15] = mk(3'd2, 1, 1, 0, 0, 32'hDDDD_0003, 1, 3'd3, 0);
        vecs[16] = mk(3'd2, 1, 0, 0, 0, 32'hBBBB_0001, 1, 3'd1, 0);
        vecs[17] = mk(3'd0, 0, 0, 0, 0, 32'hCCCC_0002, 1, 3'd2, 0);
        vecs[18] = mk(3'd3, 1, 0, 0, 0, 32'hAAAA_0000, 0, 3'd0, 0);
        vecs[19] = mk(3'd1, 1, 0, 0, 0, 32'hDDDD_0003, 1, 3'd3, 0);
        vecs[20] = mk(3'd5, 1, 1, 1, 0, 32'h0000_0000, 0, 3'd0, 0);
        vecs[21] = mk(3'd0, 0, 0, 0, 0, 32'h0000_0000, 0, 3'd0, 0);
        vecs[22] = mk(3'd5, 1, 1, 0, 0, 32'h0000_0000, 0, 3'd0, 0);
        vecs[23] = mk(3'd0, 0, 0, 0, 0, 32'hAAAA_0000, 0, 3'd0, 0);

        in_bus  = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        chk_all("reset", 32'h0, 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].sel, vecs[i].vld, vecs[i].stall, vecs[i].flush, vecs[i].clr);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                    vecs[i].e_sel, vecs[i].e_err);
        end

        // Asynchronous reset with valid data in flight and sel_err set.
        drive(3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("pre_rst", 32'hBBBB_0001, 1'b1, 3'd1, 1'b1);
        drive(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 1'b0, 3'd0, 1'b0);
        #1;
        reset_n = 1'b1;
        tick();
        chk_all("post_rst1", 32'h0, 1'b0, 3'd0, 1'b0);
        drive(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("post_rst2", 32'hAAAA_0000, 1'b1, 3'd0, 1'b0);
        tick();
        chk_all("post_rst3", 32'hDDDD_0003, 1'b1, 3'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
